// File: rtl/adder_8bit.sv
// ---------------------------------------------------------------------------
// adder_8bit
//   32-bit registered adder built from four cascaded 8-bit carry-ripple
//   slices (bits 7:0, 15:8, 23:16, 31:24). One clock of latency, accepts a
//   new operand set every cycle, no backpressure.
//
// Ports
//   clk          in   1   sole clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   a            in  32   first operand (unsigned)
//   b            in  32   second operand (unsigned)
//   retenue_prec in   1   carry-in into slice 0
//   in_valid     in   1   operands valid this cycle
//   result       out 32   registered sum bits [31:0]
//   retenue      out  1   registered carry-out of bit 31
//   overflow     out  1   registered two's-complement signed overflow
//   out_valid    out  1   one-cycle pulse when outputs hold a new sum
// ---------------------------------------------------------------------------
module adder_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        retenue_prec,
    input  logic        in_valid,
    output logic [31:0] result,
    output logic        retenue,
    output logic        overflow,
    output logic        out_valid
);

    logic [4:0]  slice_carry;   // slice_carry[s] is the carry into slice s
    logic [31:0] sum_comb;
    logic        ovf_comb;
    logic        bit_carry;

    // Each slice ripples its carry bit by bit; its final carry becomes the
    // next slice's carry-in.
    always_comb begin
        slice_carry    = '0;
        sum_comb       = '0;
        bit_carry      = 1'b0;
        slice_carry[0] = retenue_prec;
        for (int unsigned s = 0; s < 4; s++) begin
            bit_carry = slice_carry[s];
            for (int unsigned i = 0; i < 8; i++) begin
                sum_comb[s*8 + i] = a[s*8 + i] ^ b[s*8 + i] ^ bit_carry;
                bit_carry         = (a[s*8 + i] & b[s*8 + i])
                                  | (a[s*8 + i] & bit_carry)
                                  | (b[s*8 + i] & bit_carry);
            end
            slice_carry[s+1] = bit_carry;
        end
    end

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign ovf_comb = (a[31] == b[31]) && (sum_comb[31] != a[31]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            retenue   <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= sum_comb;
                retenue  <= slice_carry[4];
                overflow <= ovf_comb;
            end
        end
    end

endmodule

// File: tb/tb_adder_8bit.sv
// ---------------------------------------------------------------------------
// tb_adder_8bit
//   Self-checking bench for adder_8bit: directed vector table, hold and
//   reset sequences, then randomized operands against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_adder_8bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        retenue_prec;
    logic        in_valid;
    logic [31:0] result;
    logic        retenue;
    logic        overflow;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_8bit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .retenue_prec (retenue_prec),
        .in_valid     (in_valid),
        .result       (result),
        .retenue      (retenue),
        .overflow     (overflow),
        .out_valid    (out_valid)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] r;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vecs[9];

    // Reference expectations held by the bench
    logic [31:0] exp_r;
    logic        exp_c;
    logic        exp_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic exp_v);
        chk({name, ".result"},    result,           exp_r);
        chk({name, ".retenue"},   {31'd0, retenue},  {31'd0, exp_c});
        chk({name, ".overflow"},  {31'd0, overflow}, {31'd0, exp_o});
        chk({name, ".out_valid"}, {31'd0, out_valid},{31'd0, exp_v});
    endtask

    // Plain arithmetic model: 33-bit unsigned sum and signed range check.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
        logic [32:0] wide;
        longint      sgn;
        wide  = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
        sgn   = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
        exp_r = wide[31:0];
        exp_c = wide[32];
        exp_o = (sgn > 64'sd2147483647) || (sgn < -64'sd2147483648);
    endtask

    // Drive inputs, then sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic [31:0] sa, input logic [31:0] sb,
                        input logic sc, input logic v);
        rst_n        = r;
        a            = sa;
        b            = sb;
        retenue_prec = sc;
        in_valid     = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'd1,         32'd2,         1'b0, 32'd3,         1'b0, 1'b0};
        vecs[1] = '{32'd1,         32'd65535,     1'b0, 32'd65536,     1'b0, 1'b0};
        vecs[2] = '{32'd255,       32'd65535,     1'b0, 32'd65790,     1'b0, 1'b0};
        vecs[3] = '{32'd0,         32'd0,         1'b1, 32'd1,         1'b0, 1'b0};
        vecs[4] = '{32'h000000FF,  32'd1,         1'b0, 32'h00000100,  1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF,  32'd0,         1'b1, 32'h00000000,  1'b1, 1'b0};
        vecs[6] = '{32'h7FFFFFFF,  32'd1,         1'b0, 32'h80000000,  1'b0, 1'b1};
        vecs[7] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF,  1'b1, 1'b0};
        vecs[8] = '{32'h80000000,  32'h80000000,  1'b0, 32'h00000000,  1'b1, 1'b1};

        // Reset held two cycles with junk operands marked valid
        step(1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1);
        step(1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1);
        exp_r = '0; exp_c = 1'b0; exp_o = 1'b0;
        check_all("reset", 1'b0);

        // First valid edge after reset
        step(1'b1, 32'd1, 32'd0, 1'b0, 1'b1);
        exp_r = 32'd1; exp_c = 1'b0; exp_o = 1'b0;
        check_all("first_after_reset", 1'b1);

        // Directed table, back-to-back
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
            exp_r = vecs[i].r; exp_c = vecs[i].c; exp_o = vecs[i].o;
            check_all($sformatf("vec%0d", i), 1'b1);
        end

        // Hold: one valid sum then three idle cycles with changing operands
        step(1'b1, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1);
        exp_r = 32'h80000000; exp_c = 1'b0; exp_o = 1'b1;
        check_all("hold_load", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, $urandom, 1'($urandom_range(1)), 1'b0);
            check_all($sformatf("hold%0d", i), 1'b0);
        end

        // Reset wins over in_valid in the same cycle
        step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        exp_r = '0; exp_c = 1'b0; exp_o = 1'b0;
        check_all("reset_priority", 1'b0);

        // No dead cycle after reset release
        step(1'b1, 32'h000000FF, 32'd1, 1'b0, 1'b1);
        exp_r = 32'h00000100; exp_c = 1'b0; exp_o = 1'b0;
        check_all("post_reset", 1'b1);

        // Random stimulus against the model; idle cycles keep prior sum
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            logic        rv;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(7) == 0) ra = 32'hFFFFFFFF;
            if ($urandom_range(7) == 0) rb = 32'h7FFFFFFF;
            rc = 1'($urandom_range(1));
            rv = ($urandom_range(3) != 0);
            step(1'b1, ra, rb, rc, rv);
            if (rv) model(ra, rb, rc);
            check_all($sformatf("rand%0d", i), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
